// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum UART transmitter slice.
// Optional build macro: SUM_UART_PARITY_EN (adds an even-parity bit, 8E1 framing).
package sum_uart_pkg;

    // Transmitter FSM states; PARITY is only visited when SUM_UART_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        TX_IDLE         = 1'b1;

endpackage

// File: rtl/sum_uart_tx_fifo.sv
// Synchronous FIFO (module sum_fifo) buffering sum words ahead of the UART serialiser.
// Pointers carry one extra wrap bit so level = wr_ptr - rd_ptr spans 0..DEPTH.
// Push is ignored when full and pop is ignored when empty, so the pointers never cross.
module sum_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    import sum_uart_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards any buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for adder sum words: FIFO buffer plus 8N1 serialiser, LSB first.
// Optional build macro: SUM_UART_PARITY_EN inserts an even-parity bit after the data (8E1).
// tx is registered from the current state, so the line lags the FSM by one cycle:
// a word accepted at edge N is popped at edge N+1 and tx goes low from edge N+2.
module sum_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    import sum_uart_pkg::*;

    localparam int unsigned LW       = $clog2(DEPTH) + 1;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [15:0] baud_cnt;
    logic [15:0] baud_nxt;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_nxt;
    logic [7:0]  shreg;
    logic [7:0]  shreg_nxt;
    logic        tx_nxt;
    logic        baud_done;

    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  head;
    logic [LW-1:0] level_nxt;

`ifdef SUM_UART_PARITY_EN
    logic        parity;
`endif

    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign baud_done = (baud_cnt == BAUD_MAX);
    assign level_nxt = level + LW'(push) - LW'(pop);

    sum_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // State, counters, shift register, line output and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= TX_IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            tx       <= tx_nxt;
            busy     <= (state_nxt != IDLE) || (level_nxt != '0);
            overflow <= overflow || (in_valid && full);
        end
    end

`ifdef SUM_UART_PARITY_EN
    // Even parity of the word is captured when it is popped, before shifting destroys it.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^head;
        end
    end
`endif

    // Next-state, counter and line-level decode; every state lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        tx_nxt    = TX_IDLE;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_nxt = head;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                tx_nxt = shreg[0];
                if (baud_done) begin
                    baud_nxt  = '0;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt = '0;
`ifdef SUM_UART_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
`ifdef SUM_UART_PARITY_EN
            PARITY: begin
                tx_nxt = parity;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = STOP;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                tx_nxt = TX_IDLE;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

endmodule
